// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter, the cache controllers and the memory model.
package mem_defs;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LINE_WIDTH_DEF = 128;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick between icache and dcache; remembers the last winner.
module rr_arbiter2
  import mem_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ic_req,
  input  logic dc_req,
  input  logic mask_ic,
  input  logic mask_dc,
  output logic gnt_vld,
  output logic gnt_owner
);
  logic last_q, last_d;
  logic ic_eff, dc_eff;

  always_comb begin
    ic_eff    = ic_req & ~mask_ic;
    dc_eff    = dc_req & ~mask_dc;
    gnt_vld   = en & (ic_eff | dc_eff);
    gnt_owner = OWNER_IC;
    // On a tie the side that did not win last time gets the port.
    if (dc_eff && (!ic_eff || last_q == OWNER_IC)) gnt_owner = OWNER_DC;
    last_d    = gnt_vld ? gnt_owner : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= OWNER_DC;
    else     last_q <= last_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache refill and dcache refill/write-back.
module mem_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_ack,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_ack,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  mask_ic_q, mask_ic_d, mask_dc_q, mask_dc_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d;
  logic [LINE_WIDTH-1:0] ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic                  busy_q, busy_d;
  logic                  gnt_vld, gnt_owner;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == IDLE),
    .ic_req    (ic_req),
    .dc_req    (dc_req),
    .mask_ic   (mask_ic_q),
    .mask_dc   (mask_dc_q),
    .gnt_vld   (gnt_vld),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mask_ic_d   = mask_ic_q;
    mask_dc_d   = mask_dc_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    case (state_q)
      IDLE: begin
        mask_ic_d = 1'b0;
        mask_dc_d = 1'b0;
        if (gnt_vld) begin
          owner_d     = gnt_owner;
          mem_req_d   = 1'b1;
          mem_addr_d  = (gnt_owner == OWNER_DC) ? dc_addr : ic_addr;
          mem_we_d    = (gnt_owner == OWNER_DC) ? dc_we : 1'b0;
          mem_wdata_d = (gnt_owner == OWNER_DC) ? dc_wdata : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready) begin
          state_d = RESP;
          if (owner_q == OWNER_IC) begin
            ic_rdata_d = mem_rdata;
            ic_ack_d   = 1'b1;
          end else begin
            // Write-backs are acked but must not disturb the last read line.
            if (!mem_we_q) dc_rdata_d = mem_rdata;
            dc_ack_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q == OWNER_IC) mask_ic_d = 1'b1;
        else                     mask_dc_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IC;
      mask_ic_q   <= 1'b0;
      mask_dc_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mask_ic_q   <= mask_ic_d;
      mask_dc_q   <= mask_dc_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ack_q    <= ic_ack_d;
      dc_ack_q    <= dc_ack_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ic_ack    = ic_ack_q;
  assign dc_ack    = dc_ack_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a timestamp-based model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic          mem_ready = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  logic          ic_ack, dc_ack, mem_req, mem_we, busy;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: a transaction granted in cycle g issues in g+1, sees memory data in the first
  // cycle r > g+1 with mem_ready, acks in r+1; the acked side is masked in r+2.
  int            cyc = 0;
  bit            m_act = 0, m_own = 0, m_we = 0, m_last = 1, m_mask_ic = 0, m_mask_dc = 0;
  int            m_g = 0, m_r = -1;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0, m_ic_rd = '0, m_dc_rd = '0;
  bit            ie, de;

  always @(negedge clk) begin
    if (rst) begin
      m_act = 0; m_last = 1; m_mask_ic = 0; m_mask_dc = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_ic_rd = '0; m_dc_rd = '0;
    end
    chk("busy",      busy,      m_act);
    chk("mem_req",   mem_req,   m_act && cyc == m_g + 1);
    chk("ic_ack",    ic_ack,    m_act && m_r >= 0 && cyc == m_r + 1 && !m_own);
    chk("dc_ack",    dc_ack,    m_act && m_r >= 0 && cyc == m_r + 1 && m_own);
    chk("mem_we",    mem_we,    m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("ic_rdata",  ic_rdata,  m_ic_rd);
    chk("dc_rdata",  dc_rdata,  m_dc_rd);
    if (!rst) begin
      if (m_act) begin
        if (m_r < 0) begin
          if (cyc > m_g + 1 && mem_ready) begin
            m_r = cyc;
            if (!m_own) m_ic_rd = mem_rdata;
            else if (!m_we) m_dc_rd = mem_rdata;
          end
        end else if (cyc == m_r + 1) begin
          m_act = 0;
          if (!m_own) m_mask_ic = 1; else m_mask_dc = 1;
        end
      end else begin
        ie = ic_req && !m_mask_ic;
        de = dc_req && !m_mask_dc;
        m_mask_ic = 0; m_mask_dc = 0;
        if (ie || de) begin
          m_own = (de && (!ie || m_last == 0));
          m_act = 1; m_g = cyc; m_r = -1; m_last = m_own;
          m_addr  = m_own ? dc_addr : ic_addr;
          m_we    = m_own ? dc_we : 1'b0;
          m_wdata = m_own ? dc_wdata : '0;
        end
      end
    end
    cyc++;
  end

  // Memory model: answers mem_req after a latency, optionally with spurious ready pulses.
  int            mem_cnt = 0, fix_lat = 0;
  bit            fix_data_en = 0, spur_en = 0;
  logic [LW-1:0] fix_data = '0;

  task automatic mem_drive();
    mem_ready = 1'b0;
    mem_rdata = rnd_line();
    if (rst) mem_cnt = 0;
    else if (mem_req) begin
      mem_cnt = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
      if (spur_en && $urandom_range(0, 3) == 0) mem_ready = 1'b1;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_ready = 1'b1;
        if (fix_data_en) mem_rdata = fix_data;
      end
    end else if (spur_en && $urandom_range(0, 15) == 0) mem_ready = 1'b1;
  endtask

  task automatic next();
    @(posedge clk); #1;
    mem_drive();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
    mem_drive();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_drive();
  endtask

  localparam logic [LW-1:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
  localparam logic [LW-1:0] F6 = 128'h0F0F0F0F_12345678_CAFEF00D_00000006;
  localparam logic [LW-1:0] BAD = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;

  logic [AW-1:0] got [4];
  int            n;
  bit            ic_pend = 0, dc_pend = 0, ic_ack_s = 0, dc_ack_s = 0;

  initial begin
    // Single icache read, latency 3, then req lingers one cycle after ack.
    do_reset();
    chk("t1_reset_busy", busy, 1'b0);
    chk("t1_reset_ic_rdata", ic_rdata, '0);
    fix_lat = 3; fix_data_en = 1; fix_data = D1; spur_en = 0;
    ic_req = 1'b1; ic_addr = 32'h0000_0040;
    for (int k = 1; k <= 8; k++) begin
      next();
      if (k == 7) ic_req = 1'b0;
      chk("t1_busy", busy, k <= 5);
      chk("t1_mem_req", mem_req, k == 1);
      chk("t1_ic_ack", ic_ack, k == 5);
      if (k == 1) begin
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_we", mem_we, 1'b0);
      end
      if (k == 5) chk("t1_ic_rdata", ic_rdata, D1);
    end

    // dcache write-back, latency 2: address/data held through WAIT, dc_rdata untouched.
    fix_lat = 2;
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h100; dc_wdata = {16{8'hA5}};
    for (int k = 1; k <= 6; k++) begin
      next();
      if (k == 5) dc_req = 1'b0;
      chk("t2_mem_req", mem_req, k == 1);
      chk("t2_dc_ack", dc_ack, k == 4);
      if (k <= 3) begin
        chk("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_wdata", mem_wdata, {16{8'hA5}});
      end
      if (k == 4) chk("t2_dc_rdata", dc_rdata, '0);
    end

    // Continuous tie from reset: IC, DC, IC, DC.
    do_reset();
    fix_lat = 1; fix_data_en = 0;
    ic_req = 1'b1; ic_addr = 32'h1000;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h2000;
    n = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      next();
      if (mem_req) begin got[n] = mem_addr; n++; end
    end
    chk("t3_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk("t3_order", got[i], (i % 2 == 0) ? 32'h1000 : 32'h2000);
    ic_req = 1'b0; dc_req = 1'b0;

    // Reset during WAIT of a dcache read.
    do_reset();
    fix_lat = 4;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h300;
    next();
    next();
    chk("t5_busy_wait", busy, 1'b1);
    rst = 1'b1; mem_cnt = 0; dc_req = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_mem_addr", mem_addr, '0);
    chk("t5_rst_ic_rdata", ic_rdata, '0);
    chk("t5_rst_dc_ack", dc_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_drive();
    ic_req = 1'b1; ic_addr = 32'h500; dc_req = 1'b1; dc_addr = 32'h600;
    n = 0;
    for (int k = 0; k < 10 && n == 0; k++) begin
      next();
      chk("t5_no_dc_ack", dc_ack, 1'b0);
      if (mem_req) begin n = 1; chk("t5_first_grant", mem_addr, 32'h500); end
    end
    chk("t5_granted", n, 1);
    ic_req = 1'b0; dc_req = 1'b0;

    // Spurious mem_ready in IDLE and in ISSUE.
    do_reset();
    fix_lat = 2; fix_data_en = 1; fix_data = F6;
    mem_ready = 1'b1; mem_rdata = BAD;
    next();
    chk("t6_idle_ic_ack", ic_ack, 1'b0);
    chk("t6_idle_ic_rdata", ic_rdata, '0);
    chk("t6_idle_dc_rdata", dc_rdata, '0);
    ic_req = 1'b1; ic_addr = 32'h700;
    next();
    chk("t6_issue_mem_req", mem_req, 1'b1);
    mem_ready = 1'b1; mem_rdata = BAD;
    next();
    chk("t6_wait_ic_ack", ic_ack, 1'b0);
    chk("t6_wait_ic_rdata", ic_rdata, '0);
    next();
    next();
    chk("t6_ack", ic_ack, 1'b1);
    chk("t6_rdata", ic_rdata, F6);
    ic_req = 1'b0;
    next();

    // Random traffic with occasional resets and spurious ready pulses.
    fix_lat = 0; fix_data_en = 0; spur_en = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1; ic_pend = 0; dc_pend = 0; ic_req = 1'b0; dc_req = 1'b0;
      end
      mem_drive();
      if (!rst) begin
        if (ic_ack_s) begin
          ic_pend = 0; ic_req = ($urandom_range(0, 1) == 1);
        end else if (!ic_pend) begin
          if ($urandom_range(0, 3) == 0) begin
            ic_pend = 1; ic_req = 1'b1; ic_addr = $urandom & ~32'hF;
          end else ic_req = 1'b0;
        end else if (m_act && !m_own && $urandom_range(0, 7) == 0) ic_req = 1'b0;
        if (dc_ack_s) begin
          dc_pend = 0; dc_req = ($urandom_range(0, 1) == 1);
        end else if (!dc_pend) begin
          if ($urandom_range(0, 3) == 0) begin
            dc_pend = 1; dc_req = 1'b1; dc_addr = $urandom & ~32'hF;
            dc_we = ($urandom_range(0, 1) == 1); dc_wdata = rnd_line();
          end else dc_req = 1'b0;
        end else if (m_act && m_own && $urandom_range(0, 7) == 0) dc_req = 1'b0;
      end
      ic_ack_s = ic_ack;
      dc_ack_s = dc_ack;
    end
    ic_req = 1'b0; dc_req = 1'b0;
    for (int k = 0; k < 10; k++) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer/arbiter sharing the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path.
- Accepts line-sized requests from both requesters and grants one at a time, round-robin.
- Runs a 4-state FSM that issues the memory request, waits for `mem_ready`, then returns data and a one-cycle ack.
- Sits between the cache controllers (fetch and memory stages) and the main-memory model.

Parameters:
- ADDR_WIDTH, 32, byte-address width of requests and of `mem_addr`.
- LINE_WIDTH, 128, cache-line width of read/write data.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_req  in  1  icache line-read request; held high until ic_ack.
- ic_addr  in  ADDR_WIDTH  icache line address.
- ic_ack  out  1  one-cycle pulse; ic_rdata valid this cycle.
- ic_rdata  out  LINE_WIDTH  returned line for icache.
- dc_req  in  1  dcache request; held high until dc_ack.
- dc_we  in  1  1 = write-back line, 0 = line read.
- dc_addr  in  ADDR_WIDTH  dcache line address.
- dc_wdata  in  LINE_WIDTH  write-back data.
- dc_ack  out  1  one-cycle pulse; dc_rdata valid this cycle (reads only).
- dc_rdata  out  LINE_WIDTH  returned line for dcache.
- mem_req  out  1  one-cycle request strobe to memory.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  ADDR_WIDTH  address, held stable from mem_req until mem_ready.
- mem_wdata  out  LINE_WIDTH  write data, held stable from mem_req until mem_ready.
- mem_ready  in  1  one-cycle completion pulse from memory; mem_rdata valid.
- mem_rdata  in  LINE_WIDTH  read data from memory.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state = IDLE.
  - mem_req, mem_we, ic_ack, dc_ack, busy = 0.
  - mem_addr, mem_wdata, ic_rdata, dc_rdata = 0.
  - last_grant = DC, so icache wins the first tie.
  - mask_ic = mask_dc = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Effective request: ic_eff = ic_req & ~mask_ic; dc_eff = dc_req & ~mask_dc.
  - Masks clear at the end of any IDLE cycle.
  - If exactly one effective request: grant it.
  - If both: grant the requester that is not last_grant.
  - On grant: latch owner, addr, we (icache: we = 0), wdata; update last_grant; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_req = 1 for exactly this cycle, with latched mem_addr/mem_we/mem_wdata; go to WAIT.
- WAIT:
  - Hold mem_addr/mem_we/mem_wdata; mem_req = 0.
  - On mem_ready: latch mem_rdata into the owner's rdata register; go to RESP.
  - mem_ready in ISSUE or IDLE is ignored; memory latency is at least 1 cycle after mem_req.
- RESP:
  - Assert the owner's ack for one cycle; set the owner's mask bit; go to IDLE.
  - Write-backs also ack; dc_rdata is left unchanged for writes.
- Mask rule: a requester acked in cycle N cannot be granted in cycle N+1. Its registered req may still be high in that cycle; this rule prevents a spurious re-grant.
- Minimum turnaround:
  - Request seen in IDLE at cycle 0, ISSUE at cycle 1.
  - mem_ready at cycle 1+L (L ≥ 1).
  - Ack at cycle 2+L; earliest next grant decision at cycle 3+L.
- A request dropped after grant does not cancel the transaction; it completes and is acked.
- A new request arriving while busy waits; it is evaluated in the next IDLE.
- Reset mid-transaction aborts it without an ack; memory sees mem_req low from that point.
- ic_rdata/dc_rdata hold their value until the next read for that owner.

Decomposition:
- Shared package (mem_defs):
  - State encoding constants: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3.
  - Owner constants: OWNER_IC = 1'b0, OWNER_DC = 1'b1.
  - Default ADDR_WIDTH and LINE_WIDTH, shared with the cache controllers and the memory model.
- One natural sub-module: rr_arbiter2, the 2-way round-robin pick using last_grant and masks (combinational plus last_grant register). The FSM and datapath latches stay in mem_arbiter.

Test Plan:
- Reset, then ic_req = 1, ic_addr = 0x0000_0040, memory L = 3 returns 0xDEADBEEF_..._0001 → mem_req pulse at cycle 1 with addr 0x40, we = 0; ic_ack pulse at cycle 5 with that data; busy high cycles 1–5.
- dc_req = 1, dc_we = 1, dc_addr = 0x100, dc_wdata = 0xA5A5..A5 → mem_we = 1 and the data are held through WAIT; dc_ack pulses; dc_rdata is unchanged (0).
- ic_req and dc_req both high continuously from reset → grant order IC, DC, IC, DC; no requester is granted twice in a row; each ack is followed by an IDLE cycle in which the acked requester is masked.
- ic_req alone held high for one cycle after ic_ack → no second icache transaction; mem_req stays 0 and the FSM stays in IDLE.
- rst asserted during WAIT of a dcache read → outputs zero immediately; no dc_ack; after release, a fresh ic/dc tie grants icache first.
- Spurious mem_ready during IDLE and during ISSUE → ignored; no ack and no rdata change.
